// File: rtl/misr_compactor.sv
// ---------------------------------------------------------------------------
// misr_compactor
//
// Multiple-input signature register used as the response compactor at the
// back end of a BIST harness. A capture run starts from a loadable seed,
// folds num_patterns valid response words into a Galois-style signature and
// then compares the result against a golden value.
//
// Parameters:
//   WIDTH     - signature width (>= 2)
//   IN_WIDTH  - response word width (1 .. WIDTH)
//   POLY      - feedback taps; bit i set XORs the feedback bit into stage i
//   CNT_WIDTH - pattern counter width
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   one-cycle pulse: load seed and begin a capture run
//   seed         in   initial signature, sampled with start
//   num_patterns in   number of words to compact, sampled with start
//   golden       in   expected signature, sampled with start
//   data_valid   in   qualifies data_in
//   data_in      in   response word from the circuit under test
//   signature    out  current signature register
//   count        out  words compacted in the current run
//   busy         out  high while capturing
//   done         out  high once the run has finished
//   pass         out  final signature matched golden (only while done)
// ---------------------------------------------------------------------------
module misr_compactor #(
  parameter int               WIDTH     = 16,
  parameter int               IN_WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY      = 16'h1021,
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     seed,
  input  logic [CNT_WIDTH-1:0] num_patterns,
  input  logic [WIDTH-1:0]     golden,
  input  logic                 data_valid,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]     signature,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] target;
  logic [WIDTH-1:0]     golden_q;
  logic [WIDTH-1:0]     data_ext;
  logic [WIDTH-1:0]     next_sig;
  logic                 last_word;

  // Next signature value: shift left by one stage, inject the MSB back into
  // every tapped stage, and fold in the response word zero-extended to the
  // full signature width. Computed every cycle; the FSM decides when to use it.
  always_comb begin
    data_ext                 = '0;
    data_ext[IN_WIDTH-1:0]   = data_in;
    next_sig = {signature[WIDTH-2:0], 1'b0}
             ^ (POLY & {WIDTH{signature[WIDTH-1]}})
             ^ data_ext;
  end

  // The word arriving now is the final one of the run when the counter is
  // one short of the target. target is never zero in RUN, so the subtract
  // cannot wrap.
  always_comb begin
    last_word = (count == (target - CNT_WIDTH'(1)));
  end

  // Run-control FSM. start wins over everything else in every state so a
  // run can be restarted at any time, and the word presented alongside it is
  // dropped. busy, done and pass are registered together with the state so
  // they all change on the same edge. pass is captured on the DONE entry
  // edge; for an empty run the seed itself is the final signature, and the
  // golden input is compared directly because golden_q loads on that edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      signature <= '0;
      count     <= '0;
      target    <= '0;
      golden_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (start) begin
      signature <= seed;
      count     <= '0;
      target    <= num_patterns;
      golden_q  <= golden;
      if (num_patterns == '0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (seed == golden);
      end else begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (data_valid) begin
            signature <= next_sig;
            count     <= count + CNT_WIDTH'(1);
            if (last_word) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (next_sig == golden_q);
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_misr_compactor.sv
// ---------------------------------------------------------------------------
// tb_misr_compactor
//
// Self-checking bench for misr_compactor with WIDTH=4, IN_WIDTH=2,
// POLY=4'b0011. A behavioural model tracks run state, signature and count
// from the input sequence and every output is compared after each edge.
// ---------------------------------------------------------------------------
module tb_misr_compactor;

  localparam int W  = 4;
  localparam int IW = 2;
  localparam int CW = 8;
  localparam int POLYV = 3;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  seed;
  logic [CW-1:0] num_patterns;
  logic [W-1:0]  golden;
  logic          data_valid;
  logic [IW-1:0] data_in;
  logic [W-1:0]  signature;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          pass;

  int checks;
  int errors;

  // model state: 0 idle, 1 capturing, 2 finished
  int mPhase;
  int mSig;
  int mCnt;
  int mTgt;
  int mGold;

  misr_compactor #(
    .WIDTH(W), .IN_WIDTH(IW), .POLY(4'b0011), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed),
    .num_patterns(num_patterns), .golden(golden), .data_valid(data_valid),
    .data_in(data_in), .signature(signature), .count(count),
    .busy(busy), .done(done), .pass(pass)
  );

  // free-running clock, 10 time-unit period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // one MISR step in plain arithmetic: multiply by two modulo 16, reduce by
  // the tap polynomial when the top bit falls off, add the word (GF(2))
  function automatic int misrStep(input int s, input int d);
    int r;
    r = (s * 2) % 16;
    if (s >= 8) r = r ^ POLYV;
    return r ^ d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mSig = 0; mCnt = 0; mTgt = 0; mGold = 0;
  endtask

  // advance the model by one clock edge using the currently driven inputs
  task automatic modelEdge();
    if (start) begin
      mSig  = int'(seed);
      mCnt  = 0;
      mTgt  = int'(num_patterns);
      mGold = int'(golden);
      mPhase = (mTgt == 0) ? 2 : 1;
    end else if (mPhase == 1 && data_valid) begin
      mSig = misrStep(mSig, int'(data_in));
      mCnt++;
      if (mCnt == mTgt) mPhase = 2;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".sig"},   32'(signature), 32'(mSig));
    checkOutput({tag, ".count"}, 32'(count),     32'(mCnt));
    checkOutput({tag, ".busy"},  32'(busy),      32'(mPhase == 1));
    checkOutput({tag, ".done"},  32'(done),      32'(mPhase == 2));
    checkOutput({tag, ".pass"},  32'(pass),      32'(mPhase == 2 && mSig == mGold));
  endtask

  // drive one cycle of inputs, step the model on the edge, check after it
  task automatic applyStimulus(input string tag, input bit st, input bit v, input logic [IW-1:0] d);
    start = st; data_valid = v; data_in = d;
    @(posedge clock);
    modelEdge();
    #1;
    start = 1'b0; data_valid = 1'b0;
    checkAll(tag);
  endtask

  task automatic setRun(input int s, input int n, input int g);
    seed = W'(s); num_patterns = CW'(n); golden = W'(g);
  endtask

  int words[8];
  int n;
  int fin;
  int sent;
  int cyc;
  bit v;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = '0;
    setRun(0, 0, 0);
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clock);
    reset = 1'b0;

    // basic compaction: expected sequence 1, 3, 7 then pass
    setRun(0, 3, 7);
    applyStimulus("basic.start", 1, 0, 0);
    applyStimulus("basic.w0", 0, 1, 2'b01);
    checkOutput("basic.s1", 32'(signature), 32'h1);
    applyStimulus("basic.w1", 0, 1, 2'b01);
    checkOutput("basic.s2", 32'(signature), 32'h3);
    applyStimulus("basic.w2", 0, 1, 2'b01);
    checkOutput("basic.s3", 32'(signature), 32'h7);
    checkOutput("basic.done", 32'(done), 32'h1);
    checkOutput("basic.pass", 32'(pass), 32'h1);
    checkOutput("basic.cnt", 32'(count), 32'h3);
    applyStimulus("basic.frozen", 0, 1, 2'b11);

    // feedback path with a wrong golden
    setRun(8, 1, 2);
    applyStimulus("fb.start", 1, 0, 0);
    applyStimulus("fb.w0", 0, 1, 2'b00);
    checkOutput("fb.sig", 32'(signature), 32'h3);
    checkOutput("fb.done", 32'(done), 32'h1);
    checkOutput("fb.pass", 32'(pass), 32'h0);

    // valid gaps of two cycles between words
    setRun(0, 3, 7);
    applyStimulus("gap.start", 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("gap.word", 0, 1, 2'b01);
      if (i < 2) begin
        applyStimulus("gap.idle", 0, 0, 2'b10);
        applyStimulus("gap.idle", 0, 0, 2'b11);
        checkOutput("gap.busy", 32'(busy), 32'h1);
      end
    end
    checkOutput("gap.final", 32'(signature), 32'h7);

    // zero patterns
    setRun(5, 0, 5);
    applyStimulus("zero.start", 1, 0, 0);
    checkOutput("zero.done", 32'(done), 32'h1);
    checkOutput("zero.pass", 32'(pass), 32'h1);
    checkOutput("zero.cnt", 32'(count), 32'h0);

    // restart mid-run, coincident word discarded
    setRun(0, 3, 7);
    applyStimulus("rst.start", 1, 0, 0);
    applyStimulus("rst.w0", 0, 1, 2'b01);
    setRun(10, 2, 0);
    applyStimulus("rst.restart", 1, 1, 2'b11);
    checkOutput("rst.sig", 32'(signature), 32'hA);
    checkOutput("rst.cnt", 32'(count), 32'h0);
    applyStimulus("rst.w1", 0, 1, 2'b10);
    applyStimulus("rst.w2", 0, 1, 2'b01);
    setRun(1, 2, 0);
    applyStimulus("rst.indone", 1, 0, 0);
    checkOutput("rst.done", 32'(done), 32'h0);
    checkOutput("rst.pass", 32'(pass), 32'h0);

    // async reset between edges mid-run
    applyStimulus("ar.w0", 0, 1, 2'b11);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("ar.sig", 32'(signature), 32'h0);
    checkOutput("ar.cnt", 32'(count), 32'h0);
    checkOutput("ar.busy", 32'(busy), 32'h0);
    checkOutput("ar.done", 32'(done), 32'h0);
    checkOutput("ar.pass", 32'(pass), 32'h0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus("ar.ignored", 0, 1, 2'b11);
    applyStimulus("ar.ignored", 0, 1, 2'b01);

    // randomized runs with gaps, random golden and occasional restarts
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, 6);
      fin = $urandom_range(0, 15);
      seed = W'(fin);
      for (int i = 0; i < n; i++) begin
        words[i] = $urandom_range(0, 3);
        fin = misrStep(fin, words[i]);
      end
      num_patterns = CW'(n);
      golden = ($urandom_range(0, 1) != 0) ? W'(fin) : W'($urandom_range(0, 15));
      applyStimulus("rnd.start", 1, 0, 0);
      sent = 0; cyc = 0;
      while (sent < n && cyc < 60) begin
        v = ($urandom_range(0, 3) != 0);
        applyStimulus("rnd.cyc", 0, v, v ? IW'(words[sent]) : IW'($urandom_range(0, 3)));
        if (v) sent++;
        cyc++;
      end
      checkOutput("rnd.bound", 32'(sent), 32'(n));
      checkOutput("rnd.final", 32'(signature), 32'(fin));
      checkOutput("rnd.pass", 32'(pass), 32'(golden == W'(fin)));
      applyStimulus("rnd.hold", 0, 1, IW'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0 && n > 1) begin
        setRun($urandom_range(0, 15), n, 0);
        applyStimulus("rnd.re", 1, 0, 0);
        applyStimulus("rnd.re.w", 0, 1, IW'($urandom_range(0, 3)));
        applyStimulus("rnd.re.start", 1, 1, IW'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
